ber_monitor: RTL
================

Name: ber_monitor

Overview:
- Receive-side measurement block for the convolutional-code channel.
- It takes the transmitted reference bit stream and the received bit stream. The received stream is either corrupted by the noise generator or decoded.
- It realigns the two streams through a reference FIFO, compares them bit by bit, and reports error count, compared-bit count and error spacing over a fixed-length measurement window.
- It is the checking end of the noise-injection path: it measures the error pattern the noise block imposes.

Parameters:
- DEPTH, 16, reference FIFO depth in bits; must be a power of two and at least 2.
- WINDOW, 1000, number of compared bits per measurement window; must be at least 1.
- CNT_W, 16, width of all count outputs; counters saturate at 2^CNT_W-1.

Ports:
- clk_sig  in  1  system clock; all logic is on the rising edge.
- reset_sig  in  1  asynchronous, active-low reset.
- start_sig  in  1  one-cycle pulse that starts a window.
- ref_valid_sig  in  1  ref_bit_sig is valid this cycle.
- ref_bit_sig  in  1  transmitted reference bit.
- rx_valid_sig  in  1  rx_bit_sig is valid this cycle.
- rx_bit_sig  in  1  received bit.
- busy_sig  out  1  window in progress.
- done_sig  out  1  one-cycle pulse when the window completes.
- err_sig  out  1  one-cycle pulse on each mismatch.
- bit_cnt_sig  out  CNT_W  bits compared in the current or last window.
- err_cnt_sig  out  CNT_W  mismatches in the current or last window.
- last_gap_sig  out  CNT_W  bit distance between the two most recent errors.
- ovf_sig  out  1  sticky flag: a reference bit was dropped because the FIFO was full.
- udf_sig  out  1  sticky flag: a received bit arrived while the FIFO was empty.

Behaviour:
- Reset (reset_sig=0, asynchronous):
  - FSM goes to IDLE and the FIFO is emptied.
  - All outputs are 0.
- FSM states: IDLE, RUN, HOLD.
  - IDLE --start_sig--> RUN.
  - RUN --(bit_cnt reaches WINDOW)--> HOLD.
  - HOLD --start_sig--> RUN.
  - start_sig is ignored while in RUN.
- Entering RUN (the cycle after start_sig):
  - bit_cnt, err_cnt, last_gap, gap counter and the seen-error flag clear to 0.
  - The FIFO empties and ovf/udf clear.
  - busy_sig=1 from that cycle on.
- RUN, reference side:
  - ref_valid_sig=1 pushes ref_bit_sig into the FIFO.
  - A push when the FIFO is full drops the bit and sets ovf_sig.
- RUN, receive side: rx_valid_sig=1 with the FIFO non-empty pops the head and compares it with rx_bit_sig.
  - Every compare increments bit_cnt.
  - On a mismatch: err_cnt increments and err_sig pulses in the cycle after the compare.
- Simultaneous push and pop on the same cycle are both allowed, including when the FIFO is full (the pop frees the slot first) or empty (no bypass: the rx bit counts as underflow).
- rx_valid_sig=1 with the FIFO empty does no compare and sets udf_sig.
- Gap measurement:
  - The gap counter increments on each matching compare.
  - On a mismatch, if the seen-error flag is already set, last_gap <= gap+1; the seen-error flag is then set and gap clears.
  - The first error of a window leaves last_gap at 0.
- Completion: the compare that makes bit_cnt == WINDOW moves the FSM to HOLD.
  - done_sig=1 for exactly one cycle (the cycle after that compare).
  - busy_sig=0.
- HOLD: all counts stay frozen; inputs are ignored except start_sig.
- Saturation: every counter stops at 2^CNT_W-1 with no wrap.
- Outside RUN, valid inputs are ignored and the FIFO is not written.
- Reset asserted mid-window aborts the window immediately; no done_sig pulse is produced.
- FIFO pointers are log2(DEPTH)+1 bits wide; full/empty are decided by pointer MSB comparison.

Optional Feature:
- Macro: BER_MONITOR_BURST_EN.
- When defined:
  - Adds output max_burst_sig [CNT_W-1:0]: the longest run of consecutive mismatched compares in the window.
  - The run counter resets on any matching compare.
  - max_burst clears on entering RUN and saturates at 2^CNT_W-1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle:
  - Stimulus: assert reset_sig=0 mid-RUN; release, then drive valids without start.
  - Required: all outputs 0; no count changes; busy stays 0.
- Clean channel:
  - Stimulus: WINDOW=1000; rx = ref delayed 3 cycles; PRBS data.
  - Required: done pulses once; bit_cnt=1000, err_cnt=0, last_gap=0, ovf=udf=0.
- Periodic noise:
  - Stimulus: rx = ref XOR noise with INTERVAL=15 (one flip every 15 bits); WINDOW=1000.
  - Required: err_cnt=66 (±1 depending on phase); last_gap=15; one err_sig pulse per flip.
- FIFO bounds:
  - Stimulus: DEPTH=16; push 20 reference bits with no rx, then 1 rx valid on an empty FIFO in a fresh window.
  - Required: ovf_sig=1 after the 17th push; udf_sig=1; bit_cnt unchanged by the underflowing rx bit.
- Start handling:
  - Stimulus: pulse start_sig during RUN, then in HOLD.
  - Required: first pulse ignored (counts continue); second pulse clears counts and busy rises the next cycle.
- Burst (with BER_MONITOR_BURST_EN):
  - Stimulus: inject 4 consecutive flips, then later 2 consecutive flips.
  - Required: max_burst_sig=4, err_cnt=6.

Source files
------------

// File: rtl/ber_monitor.sv
// ber_monitor: realigns reference and received bit streams through a FIFO and
// measures errors over a window. Define BER_MONITOR_BURST_EN for max_burst_sig.
module ber_monitor #(
    parameter int DEPTH  = 16,
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 16
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             start_sig,
    input  logic             ref_valid_sig,
    input  logic             ref_bit_sig,
    input  logic             rx_valid_sig,
    input  logic             rx_bit_sig,
    output logic             busy_sig,
    output logic             done_sig,
    output logic             err_sig,
    output logic [CNT_W-1:0] bit_cnt_sig,
    output logic [CNT_W-1:0] err_cnt_sig,
    output logic [CNT_W-1:0] last_gap_sig,
    output logic             ovf_sig,
`ifdef BER_MONITOR_BURST_EN
    output logic [CNT_W-1:0] max_burst_sig,
`endif
    output logic             udf_sig
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] CWIN = CNT_W'(WINDOW);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
    state_e state_q, state_d;

    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0]  mem_q, mem_d;
    logic [CNT_W-1:0]  bits_q, bits_d, errs_q, errs_d;
    logic [CNT_W-1:0]  gap_q, gap_d, lgap_q, lgap_d;
    logic              seen_q, seen_d, ovf_q, ovf_d, udf_q, udf_d;
    logic              done_q, done_d, err_q, err_d;
    logic              running, enter, empty, full, pop, push, miss, fin;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    assign running = (state_q == RUN);
    assign enter   = start_sig && !running;
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // A pop on a full FIFO frees the slot for a same-cycle push; no empty bypass.
    assign pop     = running && rx_valid_sig && !empty;
    assign push    = running && ref_valid_sig && (!full || pop);
    assign miss    = pop && (mem_q[rd_q[AW-1:0]] != rx_bit_sig);
    assign fin     = pop && (sat_inc(bits_q) == CWIN);

    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_sig) state_d = RUN;
            RUN:     if (fin) state_d = HOLD;
            HOLD:    if (start_sig) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_sig = (state_q == RUN);
    end

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        mem_d  = mem_q;
        bits_d = bits_q;
        errs_d = errs_q;
        gap_d  = gap_q;
        lgap_d = lgap_q;
        seen_d = seen_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (enter) begin
            wr_d   = '0;
            rd_d   = '0;
            bits_d = '0;
            errs_d = '0;
            gap_d  = '0;
            lgap_d = '0;
            seen_d = 1'b0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else if (running) begin
            if (push) begin
                mem_d[wr_q[AW-1:0]] = ref_bit_sig;
                wr_d = wr_q + 1'b1;
            end
            if (ref_valid_sig && !push) ovf_d = 1'b1;
            if (rx_valid_sig && empty) udf_d = 1'b1;
            if (pop) begin
                rd_d   = rd_q + 1'b1;
                bits_d = sat_inc(bits_q);
                done_d = fin;
                if (miss) begin
                    errs_d = sat_inc(errs_q);
                    err_d  = 1'b1;
                    if (seen_q) lgap_d = sat_inc(gap_q);
                    seen_d = 1'b1;
                    gap_d  = '0;
                end else begin
                    gap_d = sat_inc(gap_q);
                end
            end
        end
    end

    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            wr_q   <= '0;
            rd_q   <= '0;
            mem_q  <= '0;
            bits_q <= '0;
            errs_q <= '0;
            gap_q  <= '0;
            lgap_q <= '0;
            seen_q <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            mem_q  <= mem_d;
            bits_q <= bits_d;
            errs_q <= errs_d;
            gap_q  <= gap_d;
            lgap_q <= lgap_d;
            seen_q <= seen_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign done_sig     = done_q;
    assign err_sig      = err_q;
    assign bit_cnt_sig  = bits_q;
    assign err_cnt_sig  = errs_q;
    assign last_gap_sig = lgap_q;
    assign ovf_sig      = ovf_q;
    assign udf_sig      = udf_q;

`ifdef BER_MONITOR_BURST_EN
    logic [CNT_W-1:0] run_q, run_d, mxb_q, mxb_d;

    always_comb begin
        run_d = run_q;
        mxb_d = mxb_q;
        if (enter) begin
            run_d = '0;
            mxb_d = '0;
        end else if (pop) begin
            if (miss) begin
                run_d = sat_inc(run_q);
                if (run_d > mxb_q) mxb_d = run_d;
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            run_q <= '0;
            mxb_q <= '0;
        end else begin
            run_q <= run_d;
            mxb_q <= mxb_d;
        end
    end

    assign max_burst_sig = mxb_q;
`endif

endmodule
